bsu_phase_sequencer: RTL
========================

Name: bsu_phase_sequencer

Overview:
Sequences the beam-steering phase LUT (10-bit address {piv[3:0], teta[5:0]}, 5-bit phase out, active-high enable, high-Z when disabled) for one commanded steering angle. On a start command it walks element index piv from 0 to NUM_ELEM-1. For each element it reads the LUT and streams the phase word to the downstream phase-shifter loader over a valid/ready handshake. After the last element it issues a single latch strobe so every element updates together. It sits between the angle-command interface and the LUT / phase-shifter serializer.

Parameters:
NUM_ELEM, 16, number of array elements sequenced per command; legal range 1..16 (piv is 4 bits).
PHASE_W, 5, LUT phase word width; fixed to match the LUT.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle command strobe; sampled only in IDLE.
teta_cmd  input  6  steering angle code; captured when start is accepted.
abort  input  1  cancels the current sequence; no latch strobe is issued.
lut_en  output  1  LUT enable.
lut_piv  output  4  LUT element-index address field.
lut_teta  output  6  LUT angle address field.
lut_phase  input  5  LUT phase data; valid only while lut_en=1.
ph_valid  output  1  phase word available downstream.
ph_ready  input  1  downstream accepts the word.
ph_data  output  5  phase word.
ph_elem  output  4  element index belonging to ph_data.
latch_pulse  output  1  one-cycle strobe; all elements apply their new phases.
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse on completion; coincident with latch_pulse.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; piv_cnt=0; teta_q=0; phase_q=0.
  - Outputs: lut_en=0, lut_piv=0, lut_teta=0, ph_valid=0, ph_data=0, ph_elem=0, latch_pulse=0, busy=0, done=0.
  - Reset overrides start and abort.
- States: IDLE, LOOKUP, PUSH, LATCH. All outputs are registered or decoded from registered state; there is no combinational path from ph_ready to ph_valid.
- IDLE:
  - busy=0.
  - When start=1: teta_q<=teta_cmd, piv_cnt<=0, next state LOOKUP.
  - start outside IDLE is ignored, and teta_cmd is not re-sampled.
- LOOKUP (one cycle):
  - lut_en=1, lut_piv=piv_cnt, lut_teta=teta_q.
  - phase_q<=lut_phase at the cycle's end edge; next state PUSH.
  - lut_en=0 in every other state, so the LUT output floats. The block must never sample lut_phase outside LOOKUP.
- PUSH:
  - ph_valid=1, ph_data=phase_q, ph_elem=piv_cnt.
  - While ph_ready=0, hold ph_data and ph_elem stable.
  - On ph_valid&&ph_ready: if piv_cnt==NUM_ELEM-1, go to LATCH; else piv_cnt<=piv_cnt+1 and go to LOOKUP.
- LATCH (one cycle): latch_pulse=1, done=1, busy=1; next state IDLE.
- busy=1 in LOOKUP, PUSH and LATCH.
- Latency with ph_ready tied high and start accepted at cycle N:
  - LOOKUP for element k at cycle N+1+2k.
  - PUSH for element k at cycle N+2+2k.
  - LATCH at cycle N+2*NUM_ELEM+1. For NUM_ELEM=16 this is N+33.
  - A start at cycle N+2*NUM_ELEM+2 (back-to-back) is accepted.
- abort:
  - Any non-IDLE state with abort=1 goes to IDLE at the next edge with piv_cnt=0.
  - latch_pulse and done are never asserted for an aborted sequence. This includes abort sampled in the LATCH cycle, which is suppressed combinationally from abort.
  - A word already accepted (valid&&ready in the same cycle as abort) counts as delivered.
  - abort in IDLE has no effect; a same-cycle start is ignored.
- NUM_ELEM=1: one LOOKUP and one PUSH, then LATCH.
- piv_cnt never exceeds NUM_ELEM-1 and does not wrap.
- Arithmetic: piv_cnt increments as unsigned 4-bit.

Optional Feature:
BSU_CAL_OFFSET_EN
- Defined:
  - Adds input cal_offset[4:0], sampled together with teta_cmd at start.
  - ph_data = (phase_q + cal_offset_q) mod 32, a 5-bit wrap-around add registered into phase_q at the end of LOOKUP. Latency is unchanged.
- Undefined: the port is absent and ph_data = raw LUT phase.

Test Plan:
1. rst=1 for 2 cycles while start=1 -> all outputs 0, busy=0, lut_en=0.
2. Stub LUT phase = (piv*3+teta)&31; ph_ready=1; start with teta_cmd=6'd5 at cycle N:
   - ph_elem 0..15 delivered with ph_data 5,8,…,(45+5)&31=18.
   - latch_pulse and done at N+33 only.
   - lut_en high exactly 16 cycles.
3. ph_ready held 0 for 4 cycles on element 3 -> ph_data and ph_elem frozen; no extra lut_en; sequence resumes; latch is delayed by exactly 4 cycles.
4. Second start with teta_cmd=9 asserted during busy -> ignored; all words use teta=5; a new start right after done is accepted.
5. abort during PUSH of element 7 -> IDLE next cycle; no latch_pulse or done; the next start restarts from element 0.
6. With BSU_CAL_OFFSET_EN, cal_offset=5'd30 and LUT phase 5'd4 -> ph_data=5'd2 (wrap-around).

Source files
------------

// File: rtl/bsu_phase_sequencer.sv
// bsu_phase_sequencer: walks LUT elements for one steering angle, streams phase words, then strobes a common latch.
// Define BSU_CAL_OFFSET_EN to add a cal_offset port whose value is added (mod 32) to every phase word.
module bsu_phase_sequencer #(
  parameter int NUM_ELEM = 16,
  parameter int PHASE_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         teta_cmd,
  input  logic               abort,
`ifdef BSU_CAL_OFFSET_EN
  input  logic [PHASE_W-1:0] cal_offset,
`endif
  output logic               lut_en,
  output logic [3:0]         lut_piv,
  output logic [5:0]         lut_teta,
  input  logic [PHASE_W-1:0] lut_phase,
  output logic               ph_valid,
  input  logic               ph_ready,
  output logic [PHASE_W-1:0] ph_data,
  output logic [3:0]         ph_elem,
  output logic               latch_pulse,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, LOOKUP, PUSH, LATCH} state_t;
  localparam logic [3:0] LAST = 4'(NUM_ELEM - 1);
  state_t state;
  logic [3:0] piv_cnt;
  logic [5:0] teta_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] off_q;
  logic accept;
  assign accept = state == IDLE && start && !abort;
`ifdef BSU_CAL_OFFSET_EN
  always_ff @(posedge clk)
    if (rst) off_q <= '0;
    else if (accept) off_q <= cal_offset;
`else
  assign off_q = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      piv_cnt <= '0;
      teta_q  <= '0;
      phase_q <= '0;
    end else if (state != IDLE && abort) begin
      state   <= IDLE;
      piv_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state   <= LOOKUP;
          teta_q  <= teta_cmd;
          piv_cnt <= '0;
        end
        LOOKUP: begin
          phase_q <= lut_phase + off_q;
          state   <= PUSH;
        end
        PUSH: if (ph_ready) begin
          if (piv_cnt == LAST) state <= LATCH;
          else begin
            piv_cnt <= piv_cnt + 4'd1;
            state   <= LOOKUP;
          end
        end
        LATCH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // outputs are pure decodes of registered state; only the latch strobe looks at abort
  always_comb begin
    lut_en      = state == LOOKUP;
    lut_piv     = lut_en ? piv_cnt : '0;
    lut_teta    = lut_en ? teta_q : '0;
    ph_valid    = state == PUSH;
    ph_data     = ph_valid ? phase_q : '0;
    ph_elem     = ph_valid ? piv_cnt : '0;
    busy        = state != IDLE;
    latch_pulse = state == LATCH && !abort;
    done        = latch_pulse;
  end
endmodule
